// File: rtl/axis_rr_arbiter_pkg.sv
// axis_arb_pkg: shared constants, slot state type and one-hot helper for the stream arbiter
//
// DATA_W_DEF : default per-source tdata width
// MAX_SRC    : largest number of sources the arbiter is meant to serve
// slot_e     : occupancy of the single output register
// onehot()   : MAX_SRC-wide one-hot vector with bit idx set
package axis_arb_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int MAX_SRC    = 8;

    typedef enum logic {
        EMPTY,
        FULL
    } slot_e;

    function automatic logic [MAX_SRC-1:0] onehot(input int unsigned idx);
        return MAX_SRC'(1) << idx;
    endfunction

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// axis_rr_arbiter_if: bundle of the per-source streams, the merged stream and status of the arbiter
//
// en_i            : per-source enable mask (0 = never granted)
// s_axis_tvalid_i : per-source valid
// s_axis_tready_o : per-source ready, one-hot or zero
// s_axis_tdata_i  : source k on bits [k*DATA_W +: DATA_W]
// m_axis_tvalid_o : merged stream valid
// m_axis_tready_i : merged stream ready
// m_axis_tdata_o  : merged data
// m_axis_tid_o    : index of the source that produced the beat
// grant_o         : one-hot of the last granted source (status)
//
// modport slave  : the arbiter's view
// modport master : the view of whatever surrounds the arbiter (sources, CPU side)
interface axis_rr_arbiter_if
    import axis_arb_pkg::*;
#(
    parameter int N_SRC  = 2,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ID_W   = 3
);

    logic [N_SRC-1:0]        en_i;
    logic [N_SRC-1:0]        s_axis_tvalid_i;
    logic [N_SRC-1:0]        s_axis_tready_o;
    logic [N_SRC*DATA_W-1:0] s_axis_tdata_i;
    logic                    m_axis_tvalid_o;
    logic                    m_axis_tready_i;
    logic [DATA_W-1:0]       m_axis_tdata_o;
    logic [ID_W-1:0]         m_axis_tid_o;
    logic [N_SRC-1:0]        grant_o;

    modport slave (
        input  en_i,
        input  s_axis_tvalid_i,
        input  s_axis_tdata_i,
        input  m_axis_tready_i,
        output s_axis_tready_o,
        output m_axis_tvalid_o,
        output m_axis_tdata_o,
        output m_axis_tid_o,
        output grant_o
    );

    modport master (
        output en_i,
        output s_axis_tvalid_i,
        output s_axis_tdata_i,
        output m_axis_tready_i,
        input  s_axis_tready_o,
        input  m_axis_tvalid_o,
        input  m_axis_tdata_o,
        input  m_axis_tid_o,
        input  grant_o
    );

endinterface

// File: rtl/axis_rr_arbiter_pick.sv
// rr_pick: combinational rotating priority encoder, first request strictly after last_ptr, wrapping
//
// req      : request vector
// last_ptr : index granted last time (search starts at last_ptr+1)
// valid    : at least one request present
// index    : chosen source index (0 when valid is low)
module rr_pick #(
    parameter int N = 2,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_ptr,
    output logic         valid,
    output logic [W-1:0] index
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             off;

    // Doubling the request vector turns the wrap-around search into a plain
    // shift: rot[j] is the request of source (last_ptr+1+j) mod N.
    always_comb begin
        dbl   = {req, req};
        rot   = N'(dbl >> (int'(last_ptr) + 1));
        valid = |rot;
        off   = 0;
        for (int j = N - 1; j >= 0; j--)
            if (rot[j]) off = j;
        index = valid ? W'((int'(last_ptr) + 1 + off) % N) : '0;
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: round-robin merge of N_SRC byte streams into one registered stream tagged with a source ID
//
// axis_aclk_i    : block clock
// axis_aresetn_i : asynchronous active-low reset (release synchronised by the parent)
// bus            : axis_rr_arbiter_if.slave, per-source streams in, merged stream out, grant status
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int N_SRC  = 2,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ID_W   = 3
) (
    input  logic                     axis_aclk_i,
    input  logic                     axis_aresetn_i,
    axis_rr_arbiter_if.slave         bus
);

    slot_e             state_q;
    slot_e             state_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] pick_data;
    logic [ID_W-1:0]   tid_q;
    logic [ID_W-1:0]   last_q;
    logic [ID_W-1:0]   pick_idx;
    logic [N_SRC-1:0]  grant_q;
    logic [N_SRC-1:0]  req;
    logic [N_SRC-1:0]  sel;
    logic              run_q;
    logic              free;
    logic              load;
    logic              pick_valid;

    rr_pick #(
        .N (N_SRC),
        .W (ID_W)
    ) u_pick (
        .req      (req),
        .last_ptr (last_q),
        .valid    (pick_valid),
        .index    (pick_idx)
    );

    // run_q keeps every ready low for the first cycle after reset release so
    // no handshake can straddle the release edge.
    always_comb begin
        req       = bus.s_axis_tvalid_i & bus.en_i;
        free      = state_q == EMPTY || bus.m_axis_tready_i;
        load      = run_q && free && pick_valid;
        state_d   = load ? FULL : (free ? EMPTY : state_q);
        sel       = N_SRC'(onehot(32'(pick_idx)));
        pick_data = '0;
        for (int k = 0; k < N_SRC; k++)
            if (sel[k]) pick_data = bus.s_axis_tdata_i[k*DATA_W +: DATA_W];
    end

    always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
        if (!axis_aresetn_i) begin
            state_q <= EMPTY;
            run_q   <= 1'b0;
            data_q  <= '0;
            tid_q   <= '0;
            last_q  <= ID_W'(N_SRC - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (load) begin
                data_q  <= pick_data;
                tid_q   <= pick_idx;
                last_q  <= pick_idx;
                grant_q <= sel;
            end
        end
    end

    assign bus.s_axis_tready_o = load ? sel : '0;
    assign bus.m_axis_tvalid_o = state_q == FULL;
    assign bus.m_axis_tdata_o  = data_q;
    assign bus.m_axis_tid_o    = tid_q;
    assign bus.grant_o         = grant_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: vector table, hand-written corner sequences and a randomized run against a reference model
module tb_axis_rr_arbiter;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int IW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axis_rr_arbiter_if #(.N_SRC(N), .DATA_W(DW), .ID_W(IW)) bus ();

    axis_rr_arbiter #(.N_SRC(N), .DATA_W(DW), .ID_W(IW)) dut (
        .axis_aclk_i    (clk),
        .axis_aresetn_i (rst_n),
        .bus            (bus)
    );

    typedef struct {
        logic [1:0] en;
        logic [1:0] sv;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       mr;
        logic [1:0] srdy;
        logic       mv;
        logic [7:0] md;
        logic [2:0] mid;
        logic [1:0] g;
    } vec_t;

    vec_t tbl[19];
    int   checks = 0;
    int   errors = 0;

    logic [1:0] r_sv;
    logic [1:0] r_en;
    logic [7:0] r_sd[2];
    logic       r_mr;
    logic       m_full;
    logic       m_run;
    logic [7:0] m_data;
    int         m_id;
    int         m_last;
    logic [1:0] m_grant;
    logic [1:0] e_srdy;
    int         pk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, a, e);
        end
    endtask

    task automatic drive(input logic [1:0] en, input logic [1:0] sv, input logic [7:0] d0,
                         input logic [7:0] d1, input logic mr);
        bus.en_i            = en;
        bus.s_axis_tvalid_i = sv;
        bus.s_axis_tdata_i  = {d1, d0};
        bus.m_axis_tready_i = mr;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string t, input logic [1:0] srdy, input logic mv, input logic [7:0] md,
                        input logic [2:0] mid, input logic [1:0] g);
        @(negedge clk);
        chk({t, "_srdy"}, 32'(bus.s_axis_tready_o), 32'(srdy));
        chk({t, "_tvalid"}, 32'(bus.m_axis_tvalid_o), 32'(mv));
        chk({t, "_grant"}, 32'(bus.grant_o), 32'(g));
        if (mv) begin
            chk({t, "_tdata"}, 32'(bus.m_axis_tdata_o), 32'(md));
            chk({t, "_tid"}, 32'(bus.m_axis_tid_o), 32'(mid));
        end
    endtask

    // First requesting source strictly after 'last' in cyclic order, -1 if none.
    function automatic int pick(input logic [1:0] req, input int last);
        for (int o = 1; o <= N; o++)
            if ((req >> ((last + o) % N)) & 2'b01) return (last + o) % N;
        return -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{2'b11, 2'b11, 8'hA0, 8'hB0, 1'b1, 2'b01, 1'b0, 8'h00, 3'd0, 2'b00};
        tbl[1]  = '{2'b11, 2'b11, 8'hA1, 8'hB0, 1'b1, 2'b10, 1'b1, 8'hA0, 3'd0, 2'b01};
        tbl[2]  = '{2'b11, 2'b11, 8'hA1, 8'hB1, 1'b1, 2'b01, 1'b1, 8'hB0, 3'd1, 2'b10};
        tbl[3]  = '{2'b11, 2'b11, 8'hA2, 8'hB1, 1'b1, 2'b10, 1'b1, 8'hA1, 3'd0, 2'b01};
        tbl[4]  = '{2'b11, 2'b11, 8'hA2, 8'hB2, 1'b1, 2'b01, 1'b1, 8'hB1, 3'd1, 2'b10};
        tbl[5]  = '{2'b11, 2'b10, 8'hA3, 8'hB2, 1'b1, 2'b10, 1'b1, 8'hA2, 3'd0, 2'b01};
        tbl[6]  = '{2'b11, 2'b10, 8'hA3, 8'h55, 1'b1, 2'b10, 1'b1, 8'hB2, 3'd1, 2'b10};
        for (int i = 7; i < 12; i++)
            tbl[i] = '{2'b11, 2'b11, 8'hA3, 8'h56, 1'b0, 2'b00, 1'b1, 8'h55, 3'd1, 2'b10};
        tbl[12] = '{2'b11, 2'b11, 8'hA3, 8'h56, 1'b1, 2'b01, 1'b1, 8'h55, 3'd1, 2'b10};
        tbl[13] = '{2'b11, 2'b10, 8'hA4, 8'h56, 1'b1, 2'b10, 1'b1, 8'hA3, 3'd0, 2'b01};
        tbl[14] = '{2'b10, 2'b11, 8'hA4, 8'h57, 1'b1, 2'b10, 1'b1, 8'h56, 3'd1, 2'b10};
        tbl[15] = '{2'b10, 2'b11, 8'hA4, 8'h58, 1'b1, 2'b10, 1'b1, 8'h57, 3'd1, 2'b10};
        tbl[16] = '{2'b11, 2'b11, 8'hA4, 8'h59, 1'b1, 2'b01, 1'b1, 8'h58, 3'd1, 2'b10};
        tbl[17] = '{2'b11, 2'b00, 8'hA4, 8'h59, 1'b1, 2'b00, 1'b1, 8'hA4, 3'd0, 2'b01};
        tbl[18] = '{2'b11, 2'b00, 8'hA4, 8'h59, 1'b1, 2'b00, 1'b0, 8'hA4, 3'd0, 2'b01};

        // Reset held with source 0 offering 0x1C.
        drive(2'b11, 2'b01, 8'h1C, 8'h00, 1'b1);
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_tvalid", 32'(bus.m_axis_tvalid_o), 32'(0));
        chk("rst_tdata", 32'(bus.m_axis_tdata_o), 32'(0));
        chk("rst_tid", 32'(bus.m_axis_tid_o), 32'(0));
        chk("rst_grant", 32'(bus.grant_o), 32'(0));
        chk("rst_srdy", 32'(bus.s_axis_tready_o), 32'(0));
        cyc();
        rst_n = 1'b1;
        outs("rel0", 2'b00, 1'b0, 8'h00, 3'd0, 2'b00);
        cyc();
        outs("rel1", 2'b01, 1'b0, 8'h00, 3'd0, 2'b00);
        cyc();
        drive(2'b11, 2'b00, 8'h1C, 8'h00, 1'b1);
        outs("rel2", 2'b00, 1'b1, 8'h1C, 3'd0, 2'b01);
        cyc();

        // Single beat then idle: grant status is retained.
        drive(2'b11, 2'b01, 8'h7E, 8'h00, 1'b1);
        outs("idle0", 2'b01, 1'b0, 8'h00, 3'd0, 2'b01);
        cyc();
        drive(2'b11, 2'b00, 8'h7E, 8'h00, 1'b1);
        outs("idle1", 2'b00, 1'b1, 8'h7E, 3'd0, 2'b01);
        cyc();
        outs("idle2", 2'b00, 1'b0, 8'h00, 3'd0, 2'b01);
        cyc();
        outs("idle3", 2'b00, 1'b0, 8'h00, 3'd0, 2'b01);
        cyc();

        // Reset while a beat is held under back-pressure.
        drive(2'b11, 2'b01, 8'h33, 8'h00, 1'b0);
        outs("mid0", 2'b01, 1'b0, 8'h00, 3'd0, 2'b01);
        cyc();
        drive(2'b11, 2'b00, 8'h33, 8'h00, 1'b0);
        outs("mid1", 2'b00, 1'b1, 8'h33, 3'd0, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_tvalid", 32'(bus.m_axis_tvalid_o), 32'(0));
        chk("mid_async_grant", 32'(bus.grant_o), 32'(0));
        drive(2'b11, 2'b11, 8'hA0, 8'hB0, 1'b1);
        cyc();
        rst_n = 1'b1;
        outs("mid_rel", 2'b00, 1'b0, 8'h00, 3'd0, 2'b00);
        cyc();

        // Alternation, back-pressure and masking, starting right after reset.
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].en, tbl[i].sv, tbl[i].d0, tbl[i].d1, tbl[i].mr);
            outs($sformatf("vec%0d", i), tbl[i].srdy, tbl[i].mv, tbl[i].md, tbl[i].mid, tbl[i].g);
            cyc();
        end

        // Randomized traffic against the reference model.
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
        r_sv    = 2'b00;
        r_en    = 2'b11;
        r_sd[0] = 8'h00;
        r_sd[1] = 8'h00;
        m_full  = 1'b0;
        m_run   = 1'b0;
        m_data  = 8'h00;
        m_id    = 0;
        m_last  = N - 1;
        m_grant = 2'b00;
        cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++)
                if (!r_sv[k] && $urandom_range(0, 2) == 0) begin
                    r_sv[k] = 1'b1;
                    r_sd[k] = 8'($urandom);
                end
            if ($urandom_range(0, 15) == 0) r_en = 2'($urandom);
            r_mr = $urandom_range(0, 3) != 0;
            drive(r_en, r_sv, r_sd[0], r_sd[1], r_mr);
            pk     = pick(r_sv & r_en, m_last);
            e_srdy = (m_run && (!m_full || r_mr) && pk >= 0) ? 2'(1 << pk) : 2'b00;
            @(negedge clk);
            chk("rnd_srdy", 32'(bus.s_axis_tready_o), 32'(e_srdy));
            chk("rnd_tvalid", 32'(bus.m_axis_tvalid_o), 32'(m_full));
            chk("rnd_grant", 32'(bus.grant_o), 32'(m_grant));
            if (m_full) begin
                chk("rnd_tdata", 32'(bus.m_axis_tdata_o), 32'(m_data));
                chk("rnd_tid", 32'(bus.m_axis_tid_o), 32'(m_id));
            end
            @(posedge clk);
            if (e_srdy != 2'b00) begin
                m_full   = 1'b1;
                m_data   = r_sd[pk];
                m_id     = pk;
                m_last   = pk;
                m_grant  = e_srdy;
                r_sv[pk] = 1'b0;
            end else if (!m_full || r_mr) begin
                m_full = 1'b0;
            end
            m_run = 1'b1;
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
